rvfi_retire_encoder: RTL and testbench

- Transmitter side of the RVFI retirement trace.
- Accepts one retirement record per cycle from a core's commit stage over a valid/ready handshake and buffers it in a small FIFO.
- Drains up to NRET records per cycle onto the RVFI channels, stamping each with a gap-free 64-bit `rvfi_order` starting at 0.
- Sits between a core's commit logic and the riscv-formal checkers, so every checker sees a well-formed, monotonically ordered stream.

---
 rtl/rvfi_retire_pkg.sv | 19 +
 rtl/rvfi_retire_fifo.sv | 54 +++++
 rtl/rvfi_retire_encoder.sv | 163 ++++++++++++++++
 tb/tb_rvfi_retire_encoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_retire_pkg.sv
// Shared types for the RVFI retirement encoder: the buffered retirement record
// and the order counter width.
package rvfi_retire_pkg;

  localparam int unsigned ORDER_W  = 64;
  // Record field width for PC/rd data; the top-level XLEN parameter should match.
  localparam int unsigned REC_XLEN = 32;

  typedef struct packed {
    logic [31:0]         insn;
    logic                trap;
    logic                halt;
    logic [REC_XLEN-1:0] pc_rdata;
    logic [REC_XLEN-1:0] pc_wdata;
    logic [4:0]          rd_addr;
    logic [REC_XLEN-1:0] rd_wdata;
  } retire_rec_t;

endpackage

// File: rtl/rvfi_retire_fifo.sv
// Circular buffer of retirement records: single push, NRET-wide peek from head,
// pop of 0..NRET entries per cycle. Caller guarantees pop_cnt_i <= count_o.
module rvfi_retire_fifo
  import rvfi_retire_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NRET  = 1,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned KW   = $clog2(NRET + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  retire_rec_t   push_rec_i,
  input  logic [KW-1:0] pop_cnt_i,
  output retire_rec_t   peek_o [NRET],
  output logic [CW-1:0] count_o
);

  retire_rec_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    head_d  = head_q + PW'(pop_cnt_i);
    tail_d  = tail_q + PW'(push_i);
    count_d = count_q + CW'(push_i) - CW'(pop_cnt_i);
    for (int i = 0; i < NRET; i++) begin
      peek_o[i] = mem_q[head_q + PW'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[tail_q] <= push_rec_i;
  end

  assign count_o = count_q;

endmodule

// File: rtl/rvfi_retire_encoder.sv
// RVFI retirement trace transmitter: buffers commit records and emits up to NRET
// per cycle with a gap-free 64-bit order. Halt support under RVFI_RETIRE_HALT_EN.
module rvfi_retire_encoder
  import rvfi_retire_pkg::*;
#(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  // in_valid/in_ready: a record transfers on any edge where both are high;
  // in_ready depends only on registered state, never on in_valid.
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_insn,
  input  logic                      in_trap,
`ifdef RVFI_RETIRE_HALT_EN
  input  logic                      in_halt,
`endif
  input  logic [XLEN-1:0]           in_pc_rdata,
  input  logic [XLEN-1:0]           in_pc_wdata,
  input  logic [4:0]                in_rd_addr,
  input  logic [XLEN-1:0]           in_rd_wdata,
  input  logic                      stall,
  output logic [NRET-1:0]           rvfi_valid,
  output logic [ORDER_W*NRET-1:0]   rvfi_order,
  output logic [32*NRET-1:0]        rvfi_insn,
  output logic [NRET-1:0]           rvfi_trap,
  output logic [NRET-1:0]           rvfi_halt,
  output logic [XLEN*NRET-1:0]      rvfi_pc_rdata,
  output logic [XLEN*NRET-1:0]      rvfi_pc_wdata,
  output logic [5*NRET-1:0]         rvfi_rd_addr,
  output logic [XLEN*NRET-1:0]      rvfi_rd_wdata
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned KW = $clog2(NRET + 1);

  retire_rec_t        push_rec;
  retire_rec_t        peek [NRET];
  logic [CW-1:0]      count;
  logic               push;
  logic [KW-1:0]      k;
  logic               halted_q;
  logic [ORDER_W-1:0] order_q, order_d;

  logic [NRET-1:0]         valid_q,  valid_d;
  logic [ORDER_W*NRET-1:0] ord_q,    ord_d;
  logic [32*NRET-1:0]      insn_q,   insn_d;
  logic [NRET-1:0]         trap_q,   trap_d;
  logic [NRET-1:0]         halt_q,   halt_d;
  logic [XLEN*NRET-1:0]    pcr_q,    pcr_d;
  logic [XLEN*NRET-1:0]    pcw_q,    pcw_d;
  logic [5*NRET-1:0]       rda_q,    rda_d;
  logic [XLEN*NRET-1:0]    rdw_q,    rdw_d;

  assign in_ready = (32'(count) < DEPTH) && !halted_q;
  assign push     = in_valid && in_ready;

  always_comb begin
    push_rec          = '0;
    push_rec.insn     = in_insn;
    push_rec.trap     = in_trap;
    push_rec.pc_rdata = REC_XLEN'(in_pc_rdata);
    push_rec.pc_wdata = REC_XLEN'(in_pc_wdata);
    push_rec.rd_addr  = in_rd_addr;
    push_rec.rd_wdata = REC_XLEN'(in_rd_wdata);
`ifdef RVFI_RETIRE_HALT_EN
    push_rec.halt     = in_halt;
`endif
  end

`ifdef RVFI_RETIRE_HALT_EN
  // Once the halt record is accepted nothing else enters until reset.
  always_ff @(posedge clock) begin
    if (reset)     halted_q <= 1'b0;
    else if (push) halted_q <= halted_q | in_halt;
  end
`else
  assign halted_q = 1'b0;
`endif

  rvfi_retire_fifo #(.DEPTH(DEPTH), .NRET(NRET)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_rec_i (push_rec),
    .pop_cnt_i  (k),
    .peek_o     (peek),
    .count_o    (count)
  );

  always_comb begin
    if (stall)                   k = '0;
    else if (32'(count) < NRET)  k = KW'(count);
    else                         k = KW'(NRET);
  end

  always_comb begin
    order_d = order_q + ORDER_W'(k);
    valid_d = '0;
    ord_d   = '0;
    insn_d  = '0;
    trap_d  = '0;
    halt_d  = '0;
    pcr_d   = '0;
    pcw_d   = '0;
    rda_d   = '0;
    rdw_d   = '0;
    for (int i = 0; i < NRET; i++) begin
      if (i < int'(k)) begin
        valid_d[i]                   = 1'b1;
        ord_d[i*ORDER_W +: ORDER_W]  = order_q + ORDER_W'(i);
        insn_d[i*32 +: 32]           = peek[i].insn;
        trap_d[i]                    = peek[i].trap;
        halt_d[i]                    = peek[i].halt;
        pcr_d[i*XLEN +: XLEN]        = XLEN'(peek[i].pc_rdata);
        pcw_d[i*XLEN +: XLEN]        = XLEN'(peek[i].pc_wdata);
        rda_d[i*5 +: 5]              = peek[i].rd_addr;
        // x0 writes are architecturally discarded, so report zero data.
        if (peek[i].rd_addr != 5'd0) rdw_d[i*XLEN +: XLEN] = XLEN'(peek[i].rd_wdata);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      order_q <= '0;
      valid_q <= '0;
      ord_q   <= '0;
      insn_q  <= '0;
      trap_q  <= '0;
      halt_q  <= '0;
      pcr_q   <= '0;
      pcw_q   <= '0;
      rda_q   <= '0;
      rdw_q   <= '0;
    end else begin
      order_q <= order_d;
      valid_q <= valid_d;
      ord_q   <= ord_d;
      insn_q  <= insn_d;
      trap_q  <= trap_d;
      halt_q  <= halt_d;
      pcr_q   <= pcr_d;
      pcw_q   <= pcw_d;
      rda_q   <= rda_d;
      rdw_q   <= rdw_d;
    end
  end

  assign rvfi_valid    = valid_q;
  assign rvfi_order    = ord_q;
  assign rvfi_insn     = insn_q;
  assign rvfi_trap     = trap_q;
  assign rvfi_halt     = halt_q;
  assign rvfi_pc_rdata = pcr_q;
  assign rvfi_pc_wdata = pcw_q;
  assign rvfi_rd_addr  = rda_q;
  assign rvfi_rd_wdata = rdw_q;

endmodule

// File: tb/tb_rvfi_retire_encoder.sv
// Bench for rvfi_retire_encoder (NRET=2, DEPTH=4): directed scenarios plus random
// traffic, checked cycle by cycle against a queue-based reference model.
module tb_rvfi_retire_encoder;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic                   clock;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_insn;
  logic                   in_trap;
  logic                   in_halt;
  logic [XLEN-1:0]        in_pc_rdata;
  logic [XLEN-1:0]        in_pc_wdata;
  logic [4:0]             in_rd_addr;
  logic [XLEN-1:0]        in_rd_wdata;
  logic                   stall;
  logic [NRET-1:0]        rvfi_valid;
  logic [64*NRET-1:0]     rvfi_order;
  logic [32*NRET-1:0]     rvfi_insn;
  logic [NRET-1:0]        rvfi_trap;
  logic [NRET-1:0]        rvfi_halt;
  logic [XLEN*NRET-1:0]   rvfi_pc_rdata;
  logic [XLEN*NRET-1:0]   rvfi_pc_wdata;
  logic [5*NRET-1:0]      rvfi_rd_addr;
  logic [XLEN*NRET-1:0]   rvfi_rd_wdata;

  rvfi_retire_encoder #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_insn       (in_insn),
    .in_trap       (in_trap),
`ifdef RVFI_RETIRE_HALT_EN
    .in_halt       (in_halt),
`endif
    .in_pc_rdata   (in_pc_rdata),
    .in_pc_wdata   (in_pc_wdata),
    .in_rd_addr    (in_rd_addr),
    .in_rd_wdata   (in_rd_wdata),
    .stall         (stall),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_trap     (rvfi_trap),
    .rvfi_halt     (rvfi_halt),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]     insn;
    logic            trap;
    logic            halt;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
  } m_rec_t;

  typedef struct packed {
    logic                 in_ready;
    logic [NRET-1:0]      valid;
    logic [64*NRET-1:0]   order;
    logic [32*NRET-1:0]   insn;
    logic [NRET-1:0]      trap;
    logic [NRET-1:0]      halt;
    logic [XLEN*NRET-1:0] pc_rdata;
    logic [XLEN*NRET-1:0] pc_wdata;
    logic [5*NRET-1:0]    rd_addr;
    logic [XLEN*NRET-1:0] rd_wdata;
  } snap_t;

  localparam int SW = $bits(snap_t);

  logic [SW-1:0] exp_q[$];
  m_rec_t        model_q[$];
  logic [63:0]   order_m;
  bit            halted_m;
  int            cyc;
  int            acc_cnt;
  int            vectors;
  int            fails;

  initial begin
    cyc     = 0;
    acc_cnt = 0;
    vectors = 0;
    fails   = 0;
    order_m = '0;
    halted_m = 0;
  end

  // Model steps on each edge with the inputs the DUT sees and predicts the
  // complete output state that follows that edge.
  always @(posedge clock) begin
    snap_t  e;
    m_rec_t r;
    int     n;
    bit     rdy;
    e = '0;
    cyc++;
    if (reset) begin
      model_q.delete();
      order_m  = '0;
      halted_m = 0;
    end else begin
      rdy = (model_q.size() < DEPTH) && !halted_m;
      if (in_valid && in_ready) acc_cnt++;
      n = stall ? 0 : ((model_q.size() < NRET) ? model_q.size() : NRET);
      for (int i = 0; i < n; i++) begin
        r = model_q.pop_front();
        e.valid[i]                 = 1'b1;
        e.order[64*i +: 64]        = order_m;
        e.insn[32*i +: 32]         = r.insn;
        e.trap[i]                  = r.trap;
        e.halt[i]                  = r.halt;
        e.pc_rdata[XLEN*i +: XLEN] = r.pc_rdata;
        e.pc_wdata[XLEN*i +: XLEN] = r.pc_wdata;
        e.rd_addr[5*i +: 5]        = r.rd_addr;
        e.rd_wdata[XLEN*i +: XLEN] = (r.rd_addr == 0) ? '0 : r.rd_wdata;
        order_m = order_m + 64'd1;
      end
      if (in_valid && rdy) begin
        r.insn     = in_insn;
        r.trap     = in_trap;
`ifdef RVFI_RETIRE_HALT_EN
        r.halt     = in_halt;
`else
        r.halt     = 1'b0;
`endif
        r.pc_rdata = in_pc_rdata;
        r.pc_wdata = in_pc_wdata;
        r.rd_addr  = in_rd_addr;
        r.rd_wdata = in_rd_wdata;
        model_q.push_back(r);
        if (r.halt) halted_m = 1;
      end
    end
    e.in_ready = (model_q.size() < DEPTH) && !halted_m;
    exp_q.push_back(e);
  end

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d got %h exp %h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clock) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = snap_t'(exp_q.pop_front());
      chk("in_ready",   128'(in_ready),   128'(e.in_ready));
      chk("rvfi_valid", 128'(rvfi_valid), 128'(e.valid));
      chk("rvfi_order", 128'(rvfi_order), 128'(e.order));
      chk("rvfi_insn",  128'(rvfi_insn),  128'(e.insn));
      chk("trap_halt",  128'({rvfi_trap, rvfi_halt}), 128'({e.trap, e.halt}));
      chk("pc",         128'({rvfi_pc_rdata, rvfi_pc_wdata}), 128'({e.pc_rdata, e.pc_wdata}));
      chk("rd_addr",    128'(rvfi_rd_addr), 128'(e.rd_addr));
      chk("rd_wdata",   128'(rvfi_rd_wdata), 128'(e.rd_wdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rec(input logic [31:0] insn, input logic [4:0] rda,
                         input logic [31:0] rdw, input logic halt);
    in_insn     = insn;
    in_trap     = 1'($urandom_range(0, 1));
    in_halt     = halt;
    in_pc_rdata = $urandom;
    in_pc_wdata = $urandom;
    in_rd_addr  = rda;
    in_rd_wdata = rdw;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset    = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] insn, input logic [4:0] rda,
                          input logic [31:0] rdw, input logic halt);
    int budget;
    budget = 50;
    while (!in_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    vectors++;
    if (!in_ready) begin
      fails++;
      $display("FAIL push_timeout cycle %0d got in_ready=0 exp 1 within 50 cycles", cyc);
    end else begin
      set_rec(insn, rda, rdw, halt);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      in_halt  = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0;
    reset    = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    set_rec(32'h0, 5'd0, 32'h0, 1'b0);
    do_reset();

    // Three back-to-back records, no stall.
    push_one(32'h13, 5'd1, $urandom, 1'b0);
    push_one(32'h93, 5'd2, $urandom, 1'b0);
    push_one(32'h113, 5'd3, $urandom, 1'b0);
    idle(6);

    // Stall with in_valid held: only DEPTH records accepted.
    acc0  = acc_cnt;
    stall = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_rec(32'h1000 + i, 5'(i + 1), $urandom, 1'b0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("stall_accepts", 128'(acc_cnt - acc0), 128'(DEPTH));
    stall = 1'b0;
    idle(6);

    // Burst drains of 4 and 3 buffered records.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_one(32'h2000 + i, 5'(i + 4), $urandom, 1'b0);
    stall = 1'b0;
    idle(4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h3000 + i, 5'(i + 8), $urandom, 1'b0);
    stall = 1'b0;
    idle(4);

    // Write to x0 reports zero data.
    push_one(32'h4033, 5'd0, 32'hDEADBEEF, 1'b0);
    idle(4);

    // Reset with records buffered; order restarts from 0.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h5000 + i, 5'd5, $urandom, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    push_one(32'h6013, 5'd6, $urandom, 1'b0);
    idle(4);

`ifdef RVFI_RETIRE_HALT_EN
    // Halt: A accepted, B (halt) accepted, C never accepted.
    do_reset();
    acc0 = acc_cnt;
    push_one(32'hA0A0, 5'd1, $urandom, 1'b0);
    push_one(32'hB0B0, 5'd2, $urandom, 1'b1);
    set_rec(32'hC0C0, 5'd3, $urandom, 1'b0);
    in_valid = 1'b1;
    repeat (25) @(negedge clock);
    in_valid = 1'b0;
    chk("halt_accepts", 128'(acc_cnt - acc0), 128'd2);
`endif

    // Random traffic with occasional stalls and resets.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      set_rec($urandom, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), $urandom, 1'b0);
      in_valid = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    stall = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
